// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   - RISC-V funct3 encodings for loads and stores
//   - we3_mode_t: register-file write-mode codes driven on wb_we3_o
//   - lsu_state_t: FSM states
//   - load_mode(): maps a load funct3 onto its write-mode code
//   - f3_illegal(): flags funct3 values that have no access behind them
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [2:0] {
        WE3_NONE = 3'b000,
        WE3_LW   = 3'b001,
        WE3_LH   = 3'b010,
        WE3_LB   = 3'b011,
        WE3_LHU  = 3'b110,
        WE3_LBU  = 3'b111
    } we3_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } lsu_state_t;

    function automatic we3_mode_t load_mode(input logic [2:0] funct3);
        we3_mode_t m;
        case (funct3)
            LB:      m = WE3_LB;
            LH:      m = WE3_LH;
            LW:      m = WE3_LW;
            LBU:     m = WE3_LBU;
            LHU:     m = WE3_LHU;
            default: m = WE3_NONE;
        endcase
        return m;
    endfunction

    // Stores only have sb/sh/sw; loads lack 011, 110 and 111.
    function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
        logic bad;
        if (we) bad = (funct3 > SW);
        else    bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the load/store unit.
// Ports:
//   funct3_i     access size/sign encoding of the incoming request
//   off_i        byte offset addr[1:0] of the incoming request
//   wdata_i      right-aligned store data
//   roff_i       byte offset of the load currently completing
//   rdata_i      raw memory read word
//   be_o         store byte enables (size mask shifted to the offset)
//   wdata_o      store data replicated across all lanes of its size
//   rdata_o      read word shifted so the addressed lane sits at bit 0
//   misaligned_o halfword on an odd address or word not on a word boundary
module lsu_lane_align #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            off_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [1:0]            roff_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [3:0]            be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misaligned_o
);

    // funct3[1:0] is the size for both loads and stores (00 byte, 01 half, 1x word).
    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o         = 4'b0011 << off_i;
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = off_i[0];
            end
            default: misaligned_o = |off_i;
        endcase
    end

    // The register file extends from bit 0, so the addressed lane is moved down.
    assign rdata_o = rdata_i >> {roff_i, 3'b000};

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multicycle load/store unit between the memory stage and
// data memory. One request per handshake; loads return through the register
// file write port (wb_we3_o / wb_wd3_o / wb_a3_o).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_*                     request handshake and fields (we, funct3, addr, wdata, rd)
//   mem_req_o .. mem_wdata_o  word-aligned memory request, held until mem_ack_i
//   mem_ack_i, mem_rdata_i    memory completion and read word
//   wb_we3_o, wb_wd3_o, wb_a3_o  register-file write mode, data, destination
//   busy_o                    FSM not idle
//   fault_o                   one-cycle pulse on misaligned/illegal access or timeout
// Build option: define LSU_TIMEOUT_EN to add an ACCESS watchdog of
// TIMEOUT_CYCLES cycles; without it ACCESS waits for the ack indefinitely.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [4:0]            req_rd_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [2:0]            wb_we3_o,
    output logic [DATA_WIDTH-1:0] wb_wd3_o,
    output logic [4:0]            wb_a3_o,
    output logic                  busy_o,
    output logic                  fault_o
);

    lsu_state_t            state_q,     state_d;
    logic                  mem_we_q,    mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [3:0]            mem_be_q,    mem_be_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]            off_q,       off_d;
    we3_mode_t             mode_q,      mode_d;
    logic [4:0]            rd_q,        rd_d;
    logic [DATA_WIDTH-1:0] wd_q,        wd_d;
    logic                  fault_q,     fault_d;

    logic [3:0]            al_be;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [DATA_WIDTH-1:0] al_rdata;
    logic                  al_misaligned;

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3_i     (req_funct3_i),
        .off_i        (req_addr_i[1:0]),
        .wdata_i      (req_wdata_i),
        .roff_i       (off_q),
        .rdata_i      (mem_rdata_i),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_misaligned)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        off_d       = off_q;
        mode_d      = mode_q;
        rd_d        = rd_q;
        wd_d        = wd_q;
        fault_d     = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    // A rejected request leaves every registered field untouched.
                    if (al_misaligned || f3_illegal(req_we_i, req_funct3_i)) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_we_d    = req_we_i;
                        mem_addr_d  = {req_addr_i[DATA_WIDTH-1:2], 2'b00};
                        mem_be_d    = req_we_i ? al_be : 4'b1111;
                        mem_wdata_d = al_wdata;
                        off_d       = req_addr_i[1:0];
                        mode_d      = load_mode(req_funct3_i);
                        rd_d        = req_rd_i;
`ifdef LSU_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end
            end
            ST_ACCESS: begin
                // The ack is checked first so it wins over a same-cycle timeout.
                if (mem_ack_i) begin
                    if (mem_we_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        wd_d    = al_rdata;
                        state_d = ST_WB;
                    end
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            off_q       <= '0;
            mode_q      <= WE3_NONE;
            rd_q        <= '0;
            wd_q        <= '0;
            fault_q     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            off_q       <= off_d;
            mode_q      <= mode_d;
            rd_q        <= rd_d;
            wd_q        <= wd_d;
            fault_q     <= fault_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign mem_req_o   = (state_q == ST_ACCESS);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;
    // x0 is hardwired, so a load to it never writes.
    assign wb_we3_o    = (state_q == ST_WB && rd_q != 5'd0) ? mode_q : WE3_NONE;
    assign wb_wd3_o    = wd_q;
    assign wb_a3_o     = rd_q;
    assign fault_o     = fault_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multicycle load/store unit for the pipelined RISC-V core, between the memory stage and data memory. Accepts one load or store per handshake, generates word-aligned memory requests with byte enables and lane-replicated store data, and for loads produces the register-file write port triple: 3-bit write-mode code, data and destination. It is the producer side of the register file's write interface. The register file sign/zero-extends from the low bits of the write data, so this block shifts loaded lanes down to bit 0.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data and address width; only 32 is supported.
- `TIMEOUT_CYCLES`, 64, watchdog limit in cycles; used only when `LSU_TIMEOUT_EN` is defined.

Ports:
- `clk`, in, 1, the single clock; all state updates on rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `req_valid_i` in 1 / `req_ready_o` out 1, request handshake.
- `req_we_i`, in, 1, 1 = store, 0 = load.
- `req_funct3_i`, in, 3, RISC-V funct3 for the access.
- `req_addr_i`, in, 32, byte address.
- `req_wdata_i`, in, 32, store data, right-aligned.
- `req_rd_i`, in, 5, load destination register.
- `mem_req_o`, out, 1, memory request, held until ack.
- `mem_we_o`, out, 1, memory write.
- `mem_addr_o`, out, 32, word address with `[1:0]`=0.
- `mem_be_o`, out, 4, byte enables.
- `mem_wdata_o`, out, 32, lane-replicated store data.
- `mem_ack_i` in 1 / `mem_rdata_i` in 32, memory completion and read word.
- `wb_we3_o`, out, 3, write mode: 000 none, 001 lw, 010 lh, 011 lb, 110 lhu, 111 lbu.
- `wb_wd3_o`, out, 32, loaded word shifted right by 8·addr[1:0].
- `wb_a3_o`, out, 5, destination register.
- `busy_o`, out, 1, state is not IDLE.
- `fault_o`, out, 1, one-cycle pulse on a misaligned access, illegal funct3 or timeout.

## Operation
- FSM states: IDLE, ACCESS, WB.
- `req_ready_o` = 1 only in IDLE. A request is accepted on `req_valid_i & req_ready_o`.
- On accept, the fields are checked:
  - Halfword with addr[0]=1, or word with addr[1:0]≠0: misaligned.
  - Load funct3 of 011, 110 or 111: illegal. Store funct3 above 010: illegal.
  - On either fault, `fault_o` pulses next cycle, the FSM stays in IDLE, and there is no memory access or writeback.
- A legal request registers `mem_addr_o` = {addr[31:2],2'b00}, the byte enables and the store data, then moves to ACCESS.
- Store lanes:
  - sb: be = 0001<<addr[1:0], wdata = {4{d[7:0]}}.
  - sh: be = 0011<<addr[1:0], wdata = {2{d[15:0]}}.
  - sw: be = 1111, wdata = d.
  - For loads, `mem_be_o` = 1111.
- ACCESS: `mem_req_o` is held at 1 with stable outputs until `mem_ack_i`.
  - Store: ack → IDLE.
  - Load: ack → `mem_rdata_i` captured → WB.
- WB: one cycle with `wb_we3_o` = mode code, `wb_wd3_o` = shifted data and `wb_a3_o` = rd, then → IDLE.
  - If rd = 0, `wb_we3_o` = 000.
- Outside WB, `wb_we3_o` = 000.

## Timing
- Reset value of every output is 0, except `req_ready_o`, which is 1 from the first cycle after reset. State resets to IDLE.
- Reset during ACCESS drops `mem_req_o` in the next cycle. The transaction is abandoned with no writeback and no fault.
- Accept at cycle 0 → `mem_req_o` = 1 at cycle 1.
- A zero-wait ack at cycle 1 gives:
  - Load: WB at cycle 2, IDLE and ready at cycle 3.
  - Store: IDLE and ready at cycle 2.
- A fault accepted at cycle 0 gives `fault_o` = 1 at cycle 1 and the block is ready again at cycle 1.
- `mem_ack_i` is ignored outside ACCESS.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A counter cleared on entry to ACCESS increments each ACCESS cycle.
  - If it reaches `TIMEOUT_CYCLES` without an ack, the block drops `mem_req_o`, pulses `fault_o`, does no writeback and returns to IDLE.
  - An ack in the same cycle as the limit wins.
- Not defined: no counter exists and ACCESS waits indefinitely.

## Structure
- Package `lsu_pkg` holds:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - A `we3_mode_t` enum with the codes above.
  - A `lsu_state_t` enum.
- One combinational sub-module, `lsu_lane_align`, computes the byte enables, the store replication, the load right-shift and the misalignment check.

## Test plan
- sw 0xDEADBEEF @0x100, ack at cycle 1 → mem_addr 0x100, be 1111, wdata 0xDEADBEEF; ready again at cycle 2; `wb_we3_o` stays 000.
- sb 0x000000A5 @0x203 → mem_addr 0x200, be 1000, wdata 0xA5A5A5A5.
- lb rd=5 @0x102, rdata 0x11803344, ack after 3 wait cycles → WB one cycle: we3 011, wd3 0x00001180, a3 5.
- lhu @0x102 → we3 110, wd3 = rdata>>16. lh @0x101 → `fault_o` pulse, no `mem_req_o`.
- rst asserted in the 2nd ACCESS cycle → next cycle `mem_req_o` 0, ready 1, no WB.
- With `LSU_TIMEOUT_EN` and TIMEOUT_CYCLES=4, no ack → `fault_o` after 4 ACCESS cycles, then IDLE.
